ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 85 ++++++++
 tb/tb_ifetch_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: a PC, a one-word instruction register and a three-state
// IDLE/FETCH/VALID controller that reads a combinational instruction memory.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        ir_ack,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] pc,
  output logic        ir_valid,
  output logic        addr_fault
);

  // Handshake: ir/ir_pc are offered while ir_valid=1 and are consumed on any
  // rising edge where ir_ack=1; they stay stable until then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] target_aligned;
  logic        out_of_range;

  assign imem_addr      = pc;
  assign ir_valid       = (state == VALID);
  assign target_aligned = {pc_target[31:2], 2'b00};
  assign out_of_range   = ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));

  // FETCH lasts exactly one cycle, so a redirect seen during it is applied at
  // that same closing edge; no pending state has to outlive the cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE: begin
        if (pc_load) pc_next = target_aligned;
        else if (fetch_req) state_next = FETCH;
      end
      FETCH: begin
        state_next = VALID;
        pc_next    = pc_load ? target_aligned : pc + 32'd4;
      end
      VALID: begin
        if (pc_load) begin
          pc_next = target_aligned;
          if (ir_ack) state_next = IDLE;
        end else if (ir_ack) begin
          state_next = fetch_req ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      ir_pc      <= 32'h0;
      addr_fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH) begin
        ir         <= out_of_range ? 32'h0 : imem_data;
        ir_pc      <= pc;
        addr_fault <= out_of_range;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a 16-word instruction memory model, so
// addresses at index 12..15 exist in the model but must be faulted by the DUT.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        ir_ack;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] pc;
  logic        ir_valid;
  logic        addr_fault;

  logic [31:0] mem [16];
  int compared;
  int mismatched;

  ifetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(12)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .ir_ack(ir_ack),
    .pc_load(pc_load), .pc_target(pc_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .ir(ir), .ir_pc(ir_pc), .pc(pc),
    .ir_valid(ir_valid), .addr_fault(addr_fault)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr[31:6] == 26'h0) imem_data = mem[imem_addr[5:2]];
  end

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mem[0] = 32'h8001_060A;
    for (int i = 1; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; fetch_req = 1'b0; ir_ack = 1'b0; pc_load = 1'b0; pc_target = 32'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_fault", {31'h0, addr_fault}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Single fetch: FETCH cycle, then VALID after one more edge
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    chk("fetch_cycle_valid", {31'h0, ir_valid}, 32'h0);
    step();
    chk("f0_ir", ir, 32'h8001_060A);
    chk("f0_ir_pc", ir_pc, 32'h0);
    chk("f0_pc", pc, 32'h4);
    chk("f0_valid", {31'h0, ir_valid}, 32'h1);
    fetch_req = 1'b1; step();
    chk("hold_valid", {31'h0, ir_valid}, 32'h1);
    chk("hold_ir", ir, 32'h8001_060A);
    chk("hold_pc", pc, 32'h4);

    // Back-to-back: ir_pc 4, 8, 12 with valid every other cycle
    ir_ack = 1'b1; fetch_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("b2b_gap_valid", {31'h0, ir_valid}, 32'h0);
      step();
      chk("b2b_valid", {31'h0, ir_valid}, 32'h1);
      chk("b2b_ir_pc", ir_pc, 32'(4 * k));
      chk("b2b_ir", ir, 32'h1000_0000 + 32'(k));
      chk("b2b_pc", pc, 32'(4 * k + 4));
    end
    fetch_req = 1'b0; step();
    chk("ack_idle_valid", {31'h0, ir_valid}, 32'h0);
    chk("ack_idle_pc", pc, 32'h10);
    ir_ack = 1'b0;

    // IDLE redirect wins over fetch_req
    pc_load = 1'b1; pc_target = 32'h0; fetch_req = 1'b1; step();
    pc_load = 1'b0; fetch_req = 1'b0;
    chk("idle_load_pc", pc, 32'h0);
    step();
    chk("idle_load_no_fetch", {31'h0, ir_valid}, 32'h0);

    // Redirect during FETCH at pc 0
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    pc_load = 1'b1; pc_target = 32'h13; step(); pc_load = 1'b0;
    chk("fredir_ir", ir, 32'h8001_060A);
    chk("fredir_ir_pc", ir_pc, 32'h0);
    chk("fredir_pc", pc, 32'h10);

    // VALID redirect with ack goes IDLE despite fetch_req
    pc_load = 1'b1; pc_target = 32'h31; ir_ack = 1'b1; fetch_req = 1'b1; step();
    pc_load = 1'b0; ir_ack = 1'b0; fetch_req = 1'b0;
    chk("vredir_valid", {31'h0, ir_valid}, 32'h0);
    chk("vredir_pc", pc, 32'h30);
    step();
    chk("vredir_stay_idle", {31'h0, ir_valid}, 32'h0);

    // Out-of-range fetch at index 12
    fetch_req = 1'b1; step(); fetch_req = 1'b0; step();
    chk("oor_ir", ir, 32'h0);
    chk("oor_fault", {31'h0, addr_fault}, 32'h1);
    chk("oor_pc", pc, 32'h34);
    chk("oor_ir_pc", ir_pc, 32'h30);

    // Redirect in VALID without ack stays VALID
    pc_load = 1'b1; pc_target = 32'h8; step(); pc_load = 1'b0;
    chk("vload_stay_valid", {31'h0, ir_valid}, 32'h1);
    chk("vload_pc", pc, 32'h8);
    chk("vload_ir_stable", ir, 32'h0);
    ir_ack = 1'b1; fetch_req = 1'b1; step(); step();
    chk("inrange_fault", {31'h0, addr_fault}, 32'h0);
    chk("inrange_ir", ir, 32'h1000_0002);
    chk("inrange_pc", pc, 32'hC);

    // PC wraps from 32'hFFFF_FFFC to 0
    fetch_req = 1'b0; step();
    ir_ack = 1'b0; pc_load = 1'b1; pc_target = 32'hFFFF_FFFF; step(); pc_load = 1'b0;
    chk("wrap_load_pc", pc, 32'hFFFF_FFFC);
    fetch_req = 1'b1; step(); fetch_req = 1'b0; step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_fault", {31'h0, addr_fault}, 32'h1);
    chk("wrap_ir", ir, 32'h0);

    // Reset during FETCH discards the fetch
    ir_ack = 1'b1; fetch_req = 1'b1; step();
    chk("pre_rst_fetch_valid", {31'h0, ir_valid}, 32'h0);
    rst = 1'b1; fetch_req = 1'b0; ir_ack = 1'b0; step(); rst = 1'b0;
    chk("midrst_valid", {31'h0, ir_valid}, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_ir", ir, 32'h0);
    chk("midrst_ir_pc", ir_pc, 32'h0);
    chk("midrst_fault", {31'h0, addr_fault}, 32'h0);
    step();
    chk("midrst_idle", {31'h0, ir_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
